data_mem_mp: RTL

- Parametrised successor to the single-core data memory: one shared word-organised data memory serving NPORTS core ports through a round-robin arbiter.
- Keeps the existing load_control/store_control encoding and adds sub-word access, sign/zero extension and a grant/rvalid handshake.
- Sits between the per-core load/store units (or L1 fill logic) and the shared memory in the multi-core integration.

---
 rtl/data_mem_mp_if.sv | 27 ++
 rtl/data_mem_mp.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_mp_if.sv
// Request/response bundle between NPORTS core load/store units and the shared data memory.
// Per-port fields are flat vectors; port i occupies slice [i*W +: W] of each field.
interface data_mem_mp_if #(
  parameter int n      = 32,
  parameter int NPORTS = 2,
  parameter int AW     = 15
);
  logic [NPORTS-1:0]   req;
  logic [NPORTS*AW-1:0] address;
  logic [NPORTS*n-1:0]  dmem_wdata;
  logic [NPORTS*3-1:0]  load_control;
  logic [NPORTS*2-1:0]  store_control;
  logic [NPORTS-1:0]    gnt;
  logic [NPORTS-1:0]    rvalid;
  logic [NPORTS*n-1:0]  dmem_rdata;
  logic [NPORTS-1:0]    err;

  modport master (
    output req, address, dmem_wdata, load_control, store_control,
    input  gnt, rvalid, dmem_rdata, err
  );

  modport slave (
    input  req, address, dmem_wdata, load_control, store_control,
    output gnt, rvalid, dmem_rdata, err
  );
endinterface

// File: rtl/data_mem_mp.sv
// Shared word-organised data memory, round-robin arbitrated across NPORTS ports; sub-word loads/stores.
// Latency: load data and rvalid one cycle after gnt; stores complete at the gnt edge.
// Backpressure: requester holds req/fields until gnt. Optional DMEM_MISALIGN_ERR_EN flags misaligned accesses.
module data_mem_mp #(
  parameter int n         = 32,
  parameter int dmem_size = 7,
  parameter int NPORTS    = 2,
  parameter int AW        = 15
) (
  input logic          clk,
  input logic          n_reset,
  data_mem_mp_if.slave bus
);

  localparam int PW    = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int NB    = n / 8;
  localparam int DEPTH = 2 ** dmem_size;

  logic [NPORTS-1:0][AW-1:0] w_addr;
  logic [NPORTS-1:0][n-1:0]  w_wdat;
  logic [NPORTS-1:0][2:0]    w_ld;
  logic [NPORTS-1:0][1:0]    w_st;
  logic [NPORTS-1:0]         w_act;

  assign w_addr = bus.address;
  assign w_wdat = bus.dmem_wdata;
  assign w_ld   = bus.load_control;
  assign w_st   = bus.store_control;

  always_comb begin
    w_act = '0;
    for (int i = 0; i < NPORTS; i++) begin
      w_act[i] = bus.req[i] && ((w_st[i] != 2'b00) ||
                                ((w_ld[i] != 3'b000) && (w_ld[i] <= 3'b101)));
    end
  end

  // Round-robin: search starts one past the last granted port.
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_sel;
  logic          w_any;

  always_comb begin
    w_sel = '0;
    w_any = 1'b0;
    for (int k = 1; k <= NPORTS; k++) begin
      int idx;
      idx = int'(r_ptr) + k;
      if (idx >= NPORTS) idx = idx - NPORTS;
      if (!w_any && w_act[idx]) begin
        w_any = 1'b1;
        w_sel = PW'(idx);
      end
    end
    if (!n_reset) w_any = 1'b0;
  end

  assign bus.gnt = w_any ? (NPORTS'(1) << w_sel) : '0;

  logic [AW-1:0] w_sa;
  logic [n-1:0]  w_swd;
  logic [2:0]    w_sld;
  logic [1:0]    w_sst;
  logic          w_is_st;
  logic          w_word;
  logic          w_half;
  logic [1:0]    w_off;
  logic          w_mis;
  logic [dmem_size-1:0] w_widx;

  assign w_sa    = w_addr[w_sel];
  assign w_swd   = w_wdat[w_sel];
  assign w_sld   = w_ld[w_sel];
  assign w_sst   = w_st[w_sel];
  assign w_is_st = (w_sst != 2'b00);
  assign w_word  = w_is_st ? (w_sst == 2'b01) : (w_sld == 3'b001);
  assign w_half  = w_is_st ? (w_sst == 2'b10) : ((w_sld == 3'b010) || (w_sld == 3'b011));
  assign w_widx  = w_sa[dmem_size+1:2];

  always_comb begin
`ifdef DMEM_MISALIGN_ERR_EN
    w_off = w_sa[1:0];
    w_mis = (w_word && (w_sa[1:0] != 2'b00)) || (w_half && w_sa[0]);
`else
    // Misaligned offsets are silently rounded down to the access size.
    if (w_word)      w_off = 2'b00;
    else if (w_half) w_off = {w_sa[1], 1'b0};
    else             w_off = w_sa[1:0];
    w_mis = 1'b0;
`endif
  end

  logic w_wr;
  logic w_rd;
  assign w_wr = w_any && !w_mis && w_is_st;
  assign w_rd = w_any && !w_mis && !w_is_st;

  logic [n-1:0] r_mem [DEPTH];
  logic [NB-1:0]      w_be;
  logic [NB-1:0][7:0] w_bdat;

  always_comb begin
    w_be   = '0;
    w_bdat = '0;
    for (int b = 0; b < NB; b++) begin
      case (w_sst)
        2'b01: begin
          w_be[b]   = 1'b1;
          w_bdat[b] = w_swd[8*b +: 8];
        end
        2'b10: begin
          w_be[b]   = ((b / 2) == int'(w_off[1]));
          w_bdat[b] = w_swd[8*(b % 2) +: 8];
        end
        2'b11: begin
          w_be[b]   = (b == int'(w_off));
          w_bdat[b] = w_swd[7:0];
        end
        default: begin
          w_be[b]   = 1'b0;
          w_bdat[b] = 8'h00;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int b = 0; b < NB; b++) begin
        if (w_be[b]) r_mem[w_widx][8*b +: 8] <= w_bdat[b];
      end
    end
  end

  logic [n-1:0] w_rword;
  logic [n-1:0] w_shft;
  logic [n-1:0] w_ext;

  assign w_rword = r_mem[w_widx];
  assign w_shft  = w_rword >> {w_off, 3'b000};

  always_comb begin
    case (w_sld)
      3'b010:  w_ext = {{(n-16){w_shft[15]}}, w_shft[15:0]};
      3'b011:  w_ext = {{(n-16){1'b0}}, w_shft[15:0]};
      3'b100:  w_ext = {{(n-8){w_shft[7]}}, w_shft[7:0]};
      3'b101:  w_ext = {{(n-8){1'b0}}, w_shft[7:0]};
      default: w_ext = w_rword;
    endcase
  end

  logic [NPORTS-1:0]        r_rvalid;
  logic [NPORTS-1:0]        r_err;
  logic [NPORTS-1:0][n-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_rvalid <= '0;
      r_err    <= '0;
      r_rdata  <= '0;
      r_ptr    <= PW'(NPORTS - 1);
    end else begin
      r_rvalid <= '0;
      r_err    <= '0;
      if (w_any) begin
        r_ptr <= w_sel;
        if (w_rd) begin
          r_rvalid[w_sel] <= 1'b1;
          r_rdata[w_sel]  <= w_ext;
        end
        if (w_mis) r_err[w_sel] <= 1'b1;
      end
    end
  end

  assign bus.rvalid     = r_rvalid;
  assign bus.err        = r_err;
  assign bus.dmem_rdata = r_rdata;

  logic w_unused;
  assign w_unused = ^w_sa[AW-1:dmem_size+2];

endmodule
